counter_seq_checker: RTL
========================

// Module: counter_seq_checker
// PURPOSE
//  Receive-side monitor for the free-running Counter block: samples a counter value stream and
//  checks each qualified sample equals previous+1 (mod 2^WIDTH). Declares lock after LOCK_CNT
//  consecutive good samples, flags and counts mismatches while locked. Sits beside any Counter
//  instance (on-board self-test, ModelSim benches) as the consumer of its q output.
// PARAMETERS
//  WIDTH     8   width of checked counter value
//  LOCK_CNT  4   consecutive good samples (incl. first) required to assert locked; legal >= 2
//  ERR_W     16  width of saturating error counter
// PORTS
//  clk        in   1       single clock, rising edge
//  sclr       in   1       synchronous reset, active-high
//  valid      in   1       din carries a sample this cycle (counter ena as seen by checker)
//  din        in   WIDTH   sampled counter value
//  expect_clr in   1       counter was cleared: next valid sample must be 0
//  err_clr    in   1       synchronous clear of err_count
//  locked     out  1       stream in LOCKED state
//  err        out  1       one-cycle pulse: mismatch detected while locked
//  err_count  out  ERR_W   saturating number of mismatches
//  expected   out  WIDTH   value required at next valid sample
// BEHAVIOUR
//  - sclr=1 at edge: state IDLE, locked=0, err=0, err_count=0, expected=0, good_cnt=0,
//    clr_pend=0. Applies mid-operation from any state; takes priority over all inputs.
//  - All outputs registered; result of a sample visible the cycle after valid=1.
//  - valid=0 cycles: no state change; gaps never break lock or count as errors.
//  - Match test: din == (clr_pend|expect_clr ? 0 : expected). expected = din+1, wraps 2^WIDTH-1 -> 0.
//  - clr_pend: set by expect_clr when valid=0 (ignored in IDLE); consumed by next valid sample.
//    expect_clr with valid=1 applies to that same sample.
//  - IDLE: valid -> expected=din+1, good_cnt=1, go SYNC. No error possible.
//  - SYNC: valid & match -> good_cnt++; good_cnt reaching LOCK_CNT -> LOCKED, locked=1.
//    valid & mismatch -> resync: expected=din+1, good_cnt=1, no err, err_count unchanged.
//  - LOCKED: valid & match -> stay. valid & mismatch -> err=1 for one cycle, err_count+1
//    (saturates at all-ones, never wraps), locked=0, resync as above into SYNC.
//  - err_clr and increment same cycle -> err_count=1; err_clr alone -> 0.
//  - Every valid sample updates expected=din+1 regardless of match.
// STRUCTURE
//  - Package counter_pkg: typedef enum logic [1:0] {CHK_IDLE, CHK_SYNC, CHK_LOCKED} chk_state_t;
//    default width constants shared with Counter (CNT_WIDTH=8).
//  - good_cnt width $clog2(LOCK_CNT+1).
//  - One sub-module: sat_counter #(W) (clk, sclr, clr, inc, q) for err_count.
// TESTING (WIDTH=8, LOCK_CNT=4 unless noted)
//  1 sclr, then valid samples 0,1,2,3,4 back-to-back -> locked=1 cycle after sample 3,
//    err never 1, err_count=0, expected=5 after sample 4.
//  2 locked; samples 253,254,255,0,1 with valid gaps of 0..3 cycles -> no err, locked stays 1.
//  3 locked, expected=11; sample 12 -> err=1 one cycle, err_count=1, locked=0;
//    samples 13,14,15 -> locked=1 after sample 15.
//  4 locked, expected=41; expect_clr pulse (valid=0), then sample 0 -> no err;
//    repeat with sample 41 after expect_clr -> err=1, err_count+1.
//  5 ERR_W=4: 20 lock/mismatch cycles -> err_count stops at 15; err_clr with concurrent
//    mismatch -> 1; err_clr alone -> 0.
//  6 sclr asserted while SYNC good_cnt=2 and err_count=3 -> next cycle locked=0,
//    err_count=0, expected=0; next sample 77 accepted as new start, no err.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the Counter block and its receive-side checker.
//   Holds the default counter width, the checker's default lock/error widths,
//   and the checker state encoding.
package counter_pkg;

  localparam int CNT_WIDTH    = 8;   // default Counter q width
  localparam int LOCK_CNT_DEF = 4;   // default consecutive-good samples to lock
  localparam int ERR_W_DEF    = 16;  // default error counter width

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_SYNC,
    CHK_LOCKED
  } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear. When clr and inc are both
//   high in the same cycle, the count restarts at 1, so that the event is not lost.
// Ports
//   clk   in  1  rising-edge clock
//   sclr  in  1  synchronous reset, active-high (highest priority)
//   clr   in  1  synchronous clear of the count
//   inc   in  1  count one event
//   q     out W  current count; holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (sclr)
      q <= '0;
    else if (clr)
      q <= inc ? W'(1) : '0;
    else if (inc && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/counter_seq_checker.sv
// counter_seq_checker
//   Monitors a free-running counter stream. Each qualified sample must equal
//   the previous sample + 1 (mod 2^WIDTH). After LOCK_CNT consecutive good
//   samples the stream is declared locked; a mismatch while locked pulses err,
//   bumps a saturating error count and drops back to resynchronisation.
// Ports
//   clk        in  1      rising-edge clock
//   sclr       in  1      synchronous reset, active-high
//   valid      in  1      din carries a sample this cycle
//   din        in  WIDTH  sampled counter value
//   expect_clr in  1      counter was cleared; next valid sample must be 0
//   err_clr    in  1      synchronous clear of err_count
//   locked     out 1      stream is locked
//   err        out 1      one-cycle pulse on mismatch while locked
//   err_count  out ERR_W  saturating mismatch count
//   expected   out WIDTH  value required at the next valid sample
module counter_seq_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  input  logic             expect_clr,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic             pend_q, pend_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             err_inc;
  logic [WIDTH-1:0] target;
  logic             match;

  // A pending or same-cycle counter clear overrides the running prediction.
  assign target   = (pend_q || expect_clr) ? '0 : exp_q;
  assign match    = (din == target);
  assign good_inc = good_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    good_d   = good_q;
    pend_d   = pend_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    err_inc  = 1'b0;
    if (valid) begin
      // Every sample re-seeds the prediction, matched or not.
      exp_d  = din + 1'b1;
      pend_d = 1'b0;
      case (state_q)
        CHK_IDLE: begin
          good_d  = GW'(1);
          state_d = CHK_SYNC;
        end
        CHK_SYNC: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d  = CHK_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_d = GW'(1);
          end
        end
        CHK_LOCKED: begin
          if (!match) begin
            err_d    = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            good_d   = GW'(1);
            state_d  = CHK_SYNC;
          end
        end
        default: begin
          state_d  = CHK_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end else if (expect_clr && (state_q != CHK_IDLE)) begin
      // Remember the clear across gaps; before the first sample there is
      // no prediction for it to override.
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q  <= CHK_IDLE;
      exp_q    <= '0;
      good_q   <= '0;
      pend_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      good_q   <= good_d;
      pend_q   <= pend_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk  (clk),
    .sclr (sclr),
    .clr  (err_clr),
    .inc  (err_inc),
    .q    (err_count)
  );

  assign locked   = locked_q;
  assign err      = err_q;
  assign expected = exp_q;

endmodule
